sar_compare_search: RTL and testbench
=====================================

Name: sar_compare_search

Overview:
Successive-approximation search controller that drives the trial operand of an external combinational magnitude comparator. It reads the comparator's greater/equal/less flags back and converges on the unknown operand held at the comparator's other input. It sits on the driving end of the comparator interface, turning the comparator into a WIDTH-bit value finder. It reports the found value, the number of compares used, and any inconsistent flag response.

Parameters:
WIDTH, 2, bit width of trial and result (legal 2..8)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a search; sampled only in IDLE
cmp_gt  input  1  comparator flag: unknown > trial
cmp_eq  input  1  comparator flag: unknown == trial
cmp_lt  input  1  comparator flag: unknown < trial
trial  output  WIDTH  registered trial value fed to the comparator
busy  output  1  high while the search is in progress
done  output  1  one-cycle pulse when the result is valid
result  output  WIDTH  found value; held until the next accepted start
cmp_count  output  4  compares used in the last search (1..WIDTH)
error  output  1  sticky flag for an inconsistent flag response; cleared on the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; trial, result and cmp_count = 0; busy, done and error = 0. Reset mid-search aborts the search immediately with no done pulse.
- The comparator is combinational. Flags are sampled on the clock edge that ends each TEST cycle, using the trial value registered during that cycle.
- FSM states: IDLE, TEST, DONE, ERR.
- IDLE: trial=0 and busy=0. On start=1, go to TEST and load:
  - trial = 1<<(WIDTH-1)
  - bit index = WIDTH-1
  - cmp_count = 0
  - error = 0
  - result is left unchanged
- TEST: busy=1. Each TEST cycle increments cmp_count by 1. Flag check first:
  - If cmp_gt+cmp_eq+cmp_lt != 1, go to ERR.
  - cmp_eq=1: result = trial; go to DONE.
  - cmp_lt=1: clear trial[idx]. If idx==0, result = trial with bit 0 cleared and go to DONE. Otherwise set trial[idx-1], decrement idx and stay in TEST.
  - cmp_gt=1: keep trial[idx]. If idx==0, this is impossible for a consistent comparator, so go to ERR. Otherwise set trial[idx-1], decrement idx and stay in TEST.
- DONE: done=1 for exactly one cycle, busy=0 and trial=0; return to IDLE.
- ERR: error is set to 1 and stays set; done is not pulsed; busy=0 and trial=0; return to IDLE. result keeps its previous value.
- Latency: with start accepted at edge 0, the search uses k TEST cycles (1 <= k <= WIDTH). done is high in cycle k+1, and result is valid from that cycle onward.
- start=1 while busy is ignored, and start held high does not retrigger during TEST. After DONE or ERR the block returns to IDLE, so start=1 in the following IDLE cycle launches a new search (back-to-back searches are allowed).
- The flags are not checked outside TEST.
- Every value in 0..2^WIDTH-1 is reachable. Value 0 is reached through the all-lt path with cmp_count=WIDTH.

Test Plan:
- WIDTH=2, unknown=2 (ideal comparator model) -> trial=2, eq on the first compare; done in cycle 2; result=2, cmp_count=1.
- WIDTH=2, sweep unknown=0,1,3 -> results 0/1/3 with cmp_count 2/2/2 and trial sequences 2→1, 2→1, 2→3; error=0.
- WIDTH=4, unknown=0 -> trials 8,4,2,1 all lt; result=0, cmp_count=4, done in cycle 5. Then unknown=15 -> trials 8,12,14,15; eq at 15; result=15.
- Fault injection: force cmp_gt=cmp_lt=1 on the first compare -> ERR, error=1, no done pulse, result unchanged. The next start clears error.
- WIDTH=2, force gt on both compares (trial 2, then 3) -> gt at idx 0 → error=1. Also: start pulsed during TEST is ignored, and cmp_count is unaffected.
- Assert rst_n=0 in the middle of a TEST cycle -> all outputs go to 0 asynchronously with no done pulse. After release, start runs a normal search to the correct result.

Source files
------------

// File: rtl/sar_compare_search_if.sv
`default_nettype none
// ============================================================================
//  Module      : sar_compare_search_if
//  Description : Signal bundle between the successive-approximation search
//                controller and its environment (start request, external
//                comparator flags, trial operand and search results).
//  Ports       : none. This interface only carries signals.
//                  start      - begin a search (environment -> controller)
//                  cmp_gt/eq/lt - comparator flags (environment -> controller)
//                  trial      - trial operand (controller -> comparator)
//                  busy, done, result, cmp_count, error - search status
//                                 (controller -> environment)
//  Modports    : master = search controller, slave = environment/comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sar_compare_search_if #(
  parameter int WIDTH = 2
);
  logic             start;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       cmp_count;
  logic             error;

  modport master (
    input  start, cmp_gt, cmp_eq, cmp_lt,
    output trial, busy, done, result, cmp_count, error
  );

  modport slave (
    output start, cmp_gt, cmp_eq, cmp_lt,
    input  trial, busy, done, result, cmp_count, error
  );
endinterface

`default_nettype wire

// File: rtl/sar_compare_search.sv
`default_nettype none
// ============================================================================
//  Module      : sar_compare_search
//  Description : Successive-approximation search controller. Drives the trial
//                operand of an external combinational magnitude comparator,
//                reads back its gt/eq/lt flags and converges on the unknown
//                operand held at the comparator's other input.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - master side of sar_compare_search_if:
//                          in : start, cmp_gt, cmp_eq, cmp_lt
//                          out: trial, busy, done, result, cmp_count, error
//  Parameters  : WIDTH - bit width of trial and result (2..8)
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_compare_search #(
  parameter int WIDTH = 2
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  sar_compare_search_if.master     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TEST = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Trial value / bit mask for the first compare: only the MSB set.
  localparam logic [WIDTH-1:0] C_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  // One-hot mask of the bit currently under test. It plays the role of the
  // bit index: bit_q[0] set means the index has reached 0.
  logic [WIDTH-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [1:0]       w_flag_sum;
  logic             w_flags_ok;
  logic [WIDTH-1:0] w_trial_clr;
  logic [WIDTH-1:0] w_bit_next;

  // A consistent comparator asserts exactly one flag.
  assign w_flag_sum  = {1'b0, bus.cmp_gt} + {1'b0, bus.cmp_eq} + {1'b0, bus.cmp_lt};
  assign w_flags_ok  = (w_flag_sum == 2'd1);
  assign w_trial_clr = trial_q & ~bit_q;
  assign w_bit_next  = bit_q >> 1;

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    bit_d    = bit_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        trial_d = '0;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d = S_TEST;
          trial_d = C_MSB;
          bit_d   = C_MSB;
          cnt_d   = 4'd0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_TEST: begin
        // Flags are evaluated against trial_q, the value presented to the
        // comparator throughout this cycle.
        cnt_d = cnt_q + 4'd1;
        if (!w_flags_ok) begin
          state_d = S_ERR;
          error_d = 1'b1;
          busy_d  = 1'b0;
          trial_d = '0;
        end else if (bus.cmp_eq) begin
          state_d  = S_DONE;
          result_d = trial_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          trial_d  = '0;
        end else if (bus.cmp_lt) begin
          if (bit_q[0]) begin
            state_d  = S_DONE;
            result_d = w_trial_clr;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            trial_d  = '0;
          end else begin
            trial_d = w_trial_clr | w_bit_next;
            bit_d   = w_bit_next;
          end
        end else begin
          // Unknown above the trial with no lower bit left to try: the
          // comparator contradicts its earlier answers.
          if (bit_q[0]) begin
            state_d = S_ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
            trial_d = '0;
          end else begin
            trial_d = trial_q | w_bit_next;
            bit_d   = w_bit_next;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        trial_d = '0;
      end

      S_ERR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        trial_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        trial_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      bit_q    <= '0;
      result_q <= '0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      bit_q    <= bit_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign bus.trial     = trial_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.cmp_count = cnt_q;
  assign bus.error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_compare_search.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_compare_search
//  Description : Directed bench for sar_compare_search with WIDTH=2 and
//                WIDTH=4 instances, each driven by a comparator model that
//                can be forced into inconsistent flag responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_compare_search;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       sel = 1'b0;     // 0: WIDTH=2 instance, 1: WIDTH=4 instance
  logic       start_r = 1'b0;
  logic [3:0] u = 4'd0;       // unknown operand at the comparator
  logic [1:0] fmode = 2'd0;   // 0 ideal, 1 gt+lt together, 2 gt always

  sar_compare_search_if #(.WIDTH(2)) if2 ();
  sar_compare_search_if #(.WIDTH(4)) if4 ();

  sar_compare_search #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  sar_compare_search #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  assign if2.start  = start_r & ~sel;
  assign if4.start  = start_r & sel;

  assign if2.cmp_gt = (fmode != 2'd0) ? 1'b1 : (u[1:0] > if2.trial);
  assign if2.cmp_eq = (fmode == 2'd0) && (u[1:0] == if2.trial);
  assign if2.cmp_lt = (fmode == 2'd1) ? 1'b1 : ((fmode == 2'd0) && (u[1:0] < if2.trial));

  assign if4.cmp_gt = (fmode != 2'd0) ? 1'b1 : (u > if4.trial);
  assign if4.cmp_eq = (fmode == 2'd0) && (u == if4.trial);
  assign if4.cmp_lt = (fmode == 2'd1) ? 1'b1 : ((fmode == 2'd0) && (u < if4.trial));

  wire [3:0] w_trial  = sel ? if4.trial  : {2'b00, if2.trial};
  wire [3:0] w_result = sel ? if4.result : {2'b00, if2.result};
  wire [3:0] w_count  = sel ? if4.cmp_count : if2.cmp_count;
  wire       w_busy   = sel ? if4.busy  : if2.busy;
  wire       w_done   = sel ? if4.done  : if2.done;
  wire       w_error  = sel ? if4.error : if2.error;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, ".trial"},  {28'd0, w_trial},  32'd0);
    check_eq({tag, ".busy"},   {31'd0, w_busy},   32'd0);
    check_eq({tag, ".done"},   {31'd0, w_done},   32'd0);
    check_eq({tag, ".result"}, {28'd0, w_result}, 32'd0);
    check_eq({tag, ".count"},  {28'd0, w_count},  32'd0);
    check_eq({tag, ".error"},  {31'd0, w_error},  32'd0);
  endtask

  // Launch one search and follow it to done or error.
  // exp_seq holds the trials seen during TEST, one per byte, oldest first.
  task automatic run_search(input string tag, input logic s, input logic [3:0] unk,
                            input logic [1:0] mode, input logic hold,
                            input logic [3:0] exp_res, input logic [3:0] exp_cnt,
                            input logic [31:0] exp_seq, input logic exp_err);
    int          cyc;
    logic [31:0] seq;
    sel   = s;
    u     = unk;
    fmode = mode;
    @(negedge clk);
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    cyc = 1;
    seq = 32'd0;
    check_eq({tag, ".err_clr"}, {31'd0, w_error}, 32'd0);
    while (!(w_done || w_error) && cyc <= 12) begin
      if (w_busy) begin
        seq     = (seq << 8) | {28'd0, w_trial};
        start_r = hold;   // start during TEST must be ignored
      end
      @(negedge clk);
      cyc++;
    end
    start_r = 1'b0;
    check_eq({tag, ".end_cyc"}, cyc, {28'd0, exp_cnt} + 32'd1);
    check_eq({tag, ".done"},    {31'd0, w_done},   {31'd0, ~exp_err});
    check_eq({tag, ".error"},   {31'd0, w_error},  {31'd0, exp_err});
    check_eq({tag, ".result"},  {28'd0, w_result}, {28'd0, exp_res});
    check_eq({tag, ".count"},   {28'd0, w_count},  {28'd0, exp_cnt});
    check_eq({tag, ".trials"},  seq, exp_seq);
    @(negedge clk);
    check_eq({tag, ".pulse"},   {31'd0, w_done},  32'd0);
    check_eq({tag, ".idle"},    {31'd0, w_busy},  32'd0);
    check_eq({tag, ".sticky"},  {31'd0, w_error}, {31'd0, exp_err});
    check_eq({tag, ".hold"},    {28'd0, w_result}, {28'd0, exp_res});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    sel = 1'b0; #1; check_idle_zero("rst2");
    sel = 1'b1; #1; check_idle_zero("rst4");
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=2, ideal comparator
    run_search("w2_u2", 1'b0, 4'd2, 2'd0, 1'b0, 4'd2, 4'd1, 32'h02,   1'b0);
    run_search("w2_u0", 1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd2, 32'h0201, 1'b0);
    run_search("w2_u1", 1'b0, 4'd1, 2'd0, 1'b0, 4'd1, 4'd2, 32'h0201, 1'b0);
    run_search("w2_u3", 1'b0, 4'd3, 2'd0, 1'b0, 4'd3, 4'd2, 32'h0203, 1'b0);
    // gt on both compares, start held high during TEST; result keeps 3
    run_search("w2_gt", 1'b0, 4'd0, 2'd2, 1'b1, 4'd3, 4'd2, 32'h0203, 1'b1);
    run_search("w2_clr", 1'b0, 4'd1, 2'd0, 1'b0, 4'd1, 4'd2, 32'h0201, 1'b0);

    // WIDTH=4
    run_search("w4_u0",  1'b1, 4'd0,  2'd0, 1'b0, 4'd0,  4'd4, 32'h08040201, 1'b0);
    run_search("w4_u15", 1'b1, 4'd15, 2'd0, 1'b0, 4'd15, 4'd4, 32'h080C0E0F, 1'b0);
    run_search("w4_bad", 1'b1, 4'd6,  2'd1, 1'b0, 4'd15, 4'd1, 32'h08,       1'b1);
    run_search("w4_u9",  1'b1, 4'd9,  2'd0, 1'b1, 4'd9,  4'd4, 32'h080C0A09, 1'b0);

    // Asynchronous reset in the middle of a TEST cycle
    sel = 1'b1; u = 4'd5; fmode = 2'd0;
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
    @(negedge clk);
    check_eq("mid.busy", {31'd0, w_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero("mid4");
    sel = 1'b0; #1; check_idle_zero("mid2");
    @(negedge clk);
    sel = 1'b1;
    check_eq("mid.nodone", {31'd0, w_done}, 32'd0);
    rst_n = 1'b1;
    run_search("w4_u5", 1'b1, 4'd5, 2'd0, 1'b0, 4'd5, 4'd4, 32'h08040605, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
